// File: rtl/qdiv_seq.sv
// qdiv_seq: operand sequencer and result formatter around the serial
// fixed-point divider qdiv2. Buffers two's-complement operand pairs in a
// 2-entry FIFO, feeds them to the divider in sign-magnitude form and
// returns a saturated two's-complement quotient over valid/ready.
//
// Optional feature macro: QDIV_SEQ_DIVZERO_EN
//   defined   - a zero divisor bypasses the divider and returns a saturated
//               result with o_res_dz = 1 and o_res_ovf = 1.
//   undefined - zero divisors go through the divider; o_res_dz is tied to 0.
module qdiv_seq #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_op_valid,
  output logic         o_op_ready,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_res_valid,
  input  logic         i_res_ready,
  output logic [N-1:0] o_res_quotient,
  output logic         o_res_ovf,
  output logic         o_res_dz,
  output logic [N-1:0] o_div_dividend,
  output logic [N-1:0] o_div_divisor,
  output logic         o_div_start,
  input  logic [N-1:0] i_div_quotient,
  input  logic         i_div_complete,
  input  logic         i_div_overflow
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] POS_MAX  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] NEG_MAX  = {1'b1, {(N-2){1'b0}}, 1'b1};
  localparam logic [N-2:0] MAG_ONE  = {{(N-2){1'b0}}, 1'b1};
  localparam logic [N-1:0] WORD_ONE = {{(N-1){1'b0}}, 1'b1};

  // The fraction width only has to agree with the divider instance; it must
  // leave at least one integer bit in the magnitude.
  if (Q >= N - 1) begin : g_q_range_check
    $error("qdiv_seq: Q must be smaller than N-1");
  end

  // Two's complement to {sat, sign, magnitude}; the most negative value has
  // no representable magnitude and is clamped to all ones.
  function automatic logic [N:0] to_sm(input logic [N-1:0] x);
    logic [N-2:0] mag;
    if (x == MOST_NEG) begin
      return {1'b1, 1'b1, {(N-1){1'b1}}};
    end
    mag = x[N-1] ? (~x[N-2:0] + MAG_ONE) : x[N-2:0];
    return {1'b0, x[N-1], mag};
  endfunction

  state_t state;
  state_t state_next;

  logic [N-1:0] fifo_dividend [2];
  logic [N-1:0] fifo_divisor  [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         ready_en;
  logic         push;
  logic         pop;
  logic         load_issue;
  logic         capture_result;
  logic         job_sat;
  logic [N-1:0] head_dividend;
  logic [N-1:0] head_divisor;
  logic [N:0]   sm_dividend;
  logic [N:0]   sm_divisor;
  logic         ovf_any;
  logic [N-1:0] q_mag_word;
  logic [N-1:0] q_format;
`ifdef QDIV_SEQ_DIVZERO_EN
  logic         head_dz;
  logic         bypass_dz;
  logic         res_dz;
`endif

  assign o_op_ready    = ready_en && (count != 2'd2);
  assign push          = i_op_valid && o_op_ready;
  assign head_dividend = fifo_dividend[rd_ptr];
  assign head_divisor  = fifo_divisor[rd_ptr];
  assign sm_dividend   = to_sm(head_dividend);
  assign sm_divisor    = to_sm(head_divisor);

  assign ovf_any    = i_div_overflow | job_sat;
  assign q_mag_word = {1'b0, i_div_quotient[N-2:0]};
  assign q_format   = ovf_any ? (i_div_quotient[N-1] ? NEG_MAX : POS_MAX)
                              : (i_div_quotient[N-1] ? (~q_mag_word + WORD_ONE) : q_mag_word);

`ifdef QDIV_SEQ_DIVZERO_EN
  assign head_dz  = (head_divisor == '0);
  assign o_res_dz = res_dz;
`else
  assign o_res_dz = 1'b0;
`endif

  // State register; reset abandons whatever job was in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state decode and the one-cycle strobes that steer the datapath.
  // A new job is only issued once the divider reports idle, so a divide
  // left running across our reset can never be captured as a result.
  always_comb begin
    state_next     = state;
    pop            = 1'b0;
    load_issue     = 1'b0;
    capture_result = 1'b0;
`ifdef QDIV_SEQ_DIVZERO_EN
    bypass_dz      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (count != 2'd0) begin
`ifdef QDIV_SEQ_DIVZERO_EN
          if (head_dz) begin
            state_next = DONE;
            pop        = 1'b1;
            bypass_dz  = 1'b1;
          end else
`endif
          if (i_div_complete) begin
            state_next = ISSUE;
            load_issue = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (!i_div_complete) begin
          state_next = BUSY;
          pop        = 1'b1;
        end
      end
      BUSY: begin
        if (i_div_complete) begin
          state_next     = DONE;
          capture_result = 1'b1;
        end
      end
      DONE: begin
        if (i_res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO pointers and occupancy; ready is held off for the reset cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are meaningless while count says empty.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_dividend[wr_ptr] <= i_dividend;
      fifo_divisor[wr_ptr]  <= i_divisor;
    end
  end

  // Divider request: operands and start held until the divider goes busy.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_div_dividend <= '0;
      o_div_divisor  <= '0;
      o_div_start    <= 1'b0;
      job_sat        <= 1'b0;
    end else if (load_issue) begin
      o_div_dividend <= sm_dividend[N-1:0];
      o_div_divisor  <= sm_divisor[N-1:0];
      o_div_start    <= 1'b1;
      job_sat        <= sm_dividend[N] | sm_divisor[N];
    end else if (pop) begin
      o_div_start    <= 1'b0;
    end
  end

  // Result register: loaded from the divider or the zero-divisor bypass,
  // held until downstream takes it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_res_valid    <= 1'b0;
      o_res_quotient <= '0;
      o_res_ovf      <= 1'b0;
`ifdef QDIV_SEQ_DIVZERO_EN
      res_dz         <= 1'b0;
`endif
    end else if (capture_result) begin
      o_res_valid    <= 1'b1;
      o_res_quotient <= q_format;
      o_res_ovf      <= ovf_any;
`ifdef QDIV_SEQ_DIVZERO_EN
      res_dz         <= 1'b0;
    end else if (bypass_dz) begin
      o_res_valid    <= 1'b1;
      o_res_quotient <= head_dividend[N-1] ? NEG_MAX : POS_MAX;
      o_res_ovf      <= 1'b1;
      res_dz         <= 1'b1;
`endif
    end else if (state == DONE && i_res_ready) begin
      o_res_valid    <= 1'b0;
    end
  end

endmodule
